// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the requester, ALU and response signals of alu_share_arbiter.
//   master : arbiter side (accepts requests, drives the ALU bus and the response)
//   slave  : environment side (requesters, the combinational ALU, response consumer)
// Signals
//   req_valid/req_ready   per-requester handshake, one bit per requester
//   req_a/req_b           32-bit operands, requester i at [32*i+:32]
//   req_op                4-bit ALU op, requester i at [4*i+:4]
//   req_tag               opaque tag, requester i at [TAG_W*i+:TAG_W]
//   alu_a/alu_b/alu_op    operand/op bus to the shared ALU
//   alu_c/alu_z           ALU result and zero flag (combinational)
//   rsp_valid/rsp_ready   output register handshake
//   rsp_c/rsp_z/rsp_id/rsp_tag  registered result, zero flag, requester index, tag
interface alu_share_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*32-1:0]    req_a;
    logic [N_REQ*32-1:0]    req_b;
    logic [N_REQ*4-1:0]     req_op;
    logic [N_REQ*TAG_W-1:0] req_tag;

    logic [31:0]            alu_a;
    logic [31:0]            alu_b;
    logic [3:0]             alu_op;
    logic [31:0]            alu_c;
    logic                   alu_z;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_c;
    logic                   rsp_z;
    logic [ID_W-1:0]        rsp_id;
    logic [TAG_W-1:0]       rsp_tag;

    modport master (
        input  req_valid, req_a, req_b, req_op, req_tag,
        input  alu_c, alu_z,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_c, rsp_z, rsp_id, rsp_tag
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, req_tag,
        output alu_c, alu_z,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_c, rsp_z, rsp_id, rsp_tag
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational RV32I ALU between N_REQ requesters. A round-robin
//   arbiter picks one valid requester, drives its operands/op onto the ALU bus
//   and captures the ALU result into a single-entry output register.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arbiter_if.master: request, ALU and response signals
// Parameters
//   N_REQ  number of requesters (2..8); must match the interface instance
//   TAG_W  tag width; must match the interface instance
module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.master   bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e        state_q,   state_d;
    logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [31:0]       rsp_c_q,   rsp_c_d;
    logic              rsp_z_q,   rsp_z_d;
    logic [ID_W-1:0]   rsp_id_q,  rsp_id_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              can_accept;
    logic              accept;

    // Round-robin scan: starts at rr_ptr and wraps modulo N_REQ, so the most
    // recently served requester is considered last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = ID_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!gnt_valid && bus.req_valid[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // The register can take a new result when empty or when the held one
    // leaves in the same cycle, which gives full throughput without a bubble.
    assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
    assign accept     = gnt_valid && can_accept;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operands follow the grant even while the output register is stalled.
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = '0;
        if (gnt_valid) begin
            bus.alu_a  = bus.req_a[32*gnt_idx +: 32];
            bus.alu_b  = bus.req_b[32*gnt_idx +: 32];
            bus.alu_op = bus.req_op[4*gnt_idx +: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_c_d   = rsp_c_q;
        rsp_z_d   = rsp_z_q;
        rsp_id_d  = rsp_id_q;
        rsp_tag_d = rsp_tag_q;
        if (accept) begin
            state_d   = FULL;
            rsp_c_d   = bus.alu_c;
            rsp_z_d   = bus.alu_z;
            rsp_id_d  = gnt_idx;
            rsp_tag_d = bus.req_tag[TAG_W*gnt_idx +: TAG_W];
            rr_ptr_d  = ID_W'((32'(gnt_idx) + 1) % N_REQ);
        end else if (state_q == FULL && bus.rsp_ready) begin
            // Drain only: data fields keep their last value.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            rr_ptr_q  <= '0;
            rsp_c_q   <= '0;
            rsp_z_q   <= 1'b0;
            rsp_id_q  <= '0;
            rsp_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_c_q   <= rsp_c_d;
            rsp_z_q   <= rsp_z_d;
            rsp_id_q  <= rsp_id_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;

    // At most one requester is ever told it was accepted.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    // A stalled response must not change under the consumer.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable(bus.rsp_c) && $stable(bus.rsp_z) &&
         $stable(bus.rsp_id) && $stable(bus.rsp_tag)));

endmodule
